// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - dot-product sequencer around a free-running pipelined 8.8 multiplier
// Optional feature macro: MAC_SEQ_SAT_EN (saturating accumulator; wraps when undefined)
module mac_sequencer #(
  parameter int VEC_LEN  = 16,
  parameter int MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  len,
  input  logic        clear,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_w,
  output logic [15:0] mult_in,
  output logic [15:0] mult_w,
  input  logic [15:0] mult_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] VEC_LEN_C = 5'(VEC_LEN);

  state_t          state;
  state_t          state_n;
  logic [4:0]      count;
  logic [15:0]     acc;
  logic [15:0]     acc_next;
  logic [MULT_LAT:0] tags;
  logic [4:0]      len_clamped;
  logic            handshake;
  logic            last_exit;

  assign len_clamped = (len > VEC_LEN_C) ? VEC_LEN_C : len;
  assign handshake   = in_valid && in_ready;
  // The final tagged product is leaving the pipe and nothing issued remains behind it.
  assign last_exit   = tags[MULT_LAT] && (tags[MULT_LAT-1:0] == '0);

  assign busy      = (state != IDLE);
  assign in_ready  = (state == FEED);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? acc : 16'h0000;

  // Accumulator adder: saturating on carry-out when enabled, modulo 2^16 otherwise.
`ifdef MAC_SEQ_SAT_EN
  logic [16:0] sum_wide;
  always_comb begin
    sum_wide = {1'b0, acc} + {1'b0, mult_out};
    acc_next = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
  end
`else
  always_comb begin
    acc_next = acc + mult_out;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; clear overrides every other transition, including start.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (len == 5'd0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (handshake && (count == 5'd1)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (last_exit) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (clear) begin
      state_n = IDLE;
    end
  end

  // Datapath: operand registers, issue-tag shadow pipe, pair count and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_in <= 16'h0000;
      mult_w  <= 16'h0000;
      tags    <= '0;
      count   <= 5'd0;
      acc     <= 16'h0000;
    end else if (clear) begin
      mult_in <= 16'h0000;
      mult_w  <= 16'h0000;
      tags    <= '0;
      count   <= 5'd0;
      acc     <= 16'h0000;
    end else begin
      mult_in <= handshake ? in_data : 16'h0000;
      mult_w  <= handshake ? in_w : 16'h0000;
      tags    <= {tags[MULT_LAT-1:0], handshake};
      if ((state == IDLE) && start) begin
        count <= len_clamped;
        acc   <= 16'h0000;
      end else begin
        if (handshake) begin
          count <= count - 5'd1;
        end
        if (tags[MULT_LAT]) begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule
